// File: rtl/adder_bist.sv
// adder_bist: built-in self-test controller for a 32-bit combinational adder.
// Two Galois LFSRs produce operand pairs on a/b; the adder result z is checked
// against an internal a+b reference, two cycles per vector (DRIVE, CHECK).
// Optional feature: define ADDER_BIST_FAIL_CAPTURE_EN to add the fail_a/fail_b/
// fail_z ports, which latch the first mismatching vector of a run.
module adder_bist #(
   parameter logic [31:0] NUM_OF_TESTS = 32'd64,
   parameter logic [31:0] SEED_A       = 32'h3C6E_F372,
   parameter logic [31:0] SEED_B       = 32'hA54F_F53A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] a,
   output logic [31:0] b,
   input  logic [31:0] z,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] vectornum,
   output logic [31:0] errors
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   ,
   output logic [31:0] fail_a,
   output logic [31:0] fail_b,
   output logic [31:0] fail_z
`endif
);

   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
   // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
   localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
   localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] vectornum_q, vectornum_d;
   logic [31:0] errors_q, errors_d;
   logic [31:0] z_correct;
   logic        mismatch;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   logic [31:0] fail_a_q, fail_a_d;
   logic [31:0] fail_b_q, fail_b_d;
   logic [31:0] fail_z_q, fail_z_d;
`endif

   // Galois right-shift step for x^32+x^22+x^2+x+1; never maps a nonzero value to 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      lfsr_step = (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'd0);
   endfunction

   // Reference sum; the carry-out is intentionally dropped.
   assign z_correct = a_q + b_q;
   assign mismatch  = (z != z_correct);

   // Next-state and datapath update: load seeds on start, check and advance in CHECK.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      vectornum_d = vectornum_q;
      errors_d    = errors_q;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
      fail_a_d    = fail_a_q;
      fail_b_d    = fail_b_q;
      fail_z_d    = fail_z_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d         = SEED_A_EFF;
               b_d         = SEED_B_EFF;
               vectornum_d = 32'd0;
               errors_d    = 32'd0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
               fail_a_d    = 32'd0;
               fail_b_d    = 32'd0;
               fail_z_d    = 32'd0;
`endif
               state_d     = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            // Operands were stable for a full cycle; the adder output is settled.
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            vectornum_d = vectornum_q + 32'd1;
            if (mismatch) begin
               errors_d = errors_q + 32'd1;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
               // errors_q is zero only until the first mismatch of this run.
               if (errors_q == 32'd0) begin
                  fail_a_d = a_q;
                  fail_b_d = b_q;
                  fail_z_d = z;
               end
`endif
            end
            a_d     = lfsr_step(a_q);
            b_d     = lfsr_step(b_q);
            state_d = (vectornum_d == NUM_OF_TESTS) ? ST_DONE : ST_DRIVE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and status registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         vectornum_q <= 32'd0;
         errors_q    <= 32'd0;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         fail_a_q    <= 32'd0;
         fail_b_q    <= 32'd0;
         fail_z_q    <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         vectornum_q <= vectornum_d;
         errors_q    <= errors_d;
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
         fail_a_q    <= fail_a_d;
         fail_b_q    <= fail_b_d;
         fail_z_q    <= fail_z_d;
`endif
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign vectornum = vectornum_q;
   assign errors    = errors_q;
   assign busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
   assign done      = (state_q == ST_DONE);
   // Decoded only from flops, so it cannot glitch on z.
   assign pass      = done && (errors_q == 32'd0);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign fail_z    = fail_z_q;
`endif

endmodule
